mmio_uart_bridge: RTL

- Memory-mapped IO slave on the datapath's IO path.
- Takes the X-stage address, store mask and load select, and returns load data registered into the M stage, replacing the constant IO read data.
- Buffers bytes between the CPU and an external UART transmitter/receiver pair through two FIFOs with ready/valid handshakes.
- Also provides cycle and retired-instruction counters.

---
 rtl/mmio_uart_bridge.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mmio_uart_bridge.sv
// MMIO slave bridging the CPU IO path to a UART TX/RX pair through two FIFOs.
// Define MMIO_COUNTERS_EN to include the CYCLES/INSTRS counters at offsets 0x10/0x14.
module mmio_uart_bridge #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] IO_BASE    = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  store_mask,
  input  logic [31:0] wdata,
  input  logic        load_sel,
  input  logic        load_en,
  output logic [31:0] rdata,
  input  logic        instr_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [5:0] OFF_STATUS = 6'h00;
  localparam logic [5:0] OFF_RXDATA = 6'h01;
  localparam logic [5:0] OFF_TXDATA = 6'h02;
  localparam logic [5:0] OFF_CYCLES = 6'h04;
  localparam logic [5:0] OFF_INSTRS = 6'h05;

  logic [5:0] offset;
  logic       hit, rdAccess, wrAccess;

  assign hit      = (addr[31:28] == IO_BASE);
  assign offset   = addr[7:2];
  assign rdAccess = hit & load_sel & load_en;
  assign wrAccess = hit & (store_mask != 4'b0000);

  // Extra pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0] txWr, txRd, rxWr, rxRd;
  logic [7:0]  txMem [FIFO_DEPTH];
  logic [7:0]  rxMem [FIFO_DEPTH];
  logic        txEmpty, txFull, rxEmpty, rxFull;
  logic        txOverflow;

  assign txEmpty = (txWr == txRd);
  assign txFull  = (txWr[AW] != txRd[AW]) && (txWr[AW-1:0] == txRd[AW-1:0]);
  assign rxEmpty = (rxWr == rxRd);
  assign rxFull  = (rxWr[AW] != rxRd[AW]) && (rxWr[AW-1:0] == rxRd[AW-1:0]);

  logic txWriteHit, txPush, txPop, rxPush, rxPop, statusRead;

  assign txWriteHit = wrAccess && (offset == OFF_TXDATA);
  assign txPush     = txWriteHit && !txFull;
  assign txPop      = !txEmpty && uart_tx_ready;
  assign rxPush     = uart_rx_valid && !rxFull;
  assign rxPop      = rdAccess && (offset == OFF_RXDATA) && !rxEmpty;
  assign statusRead = rdAccess && (offset == OFF_STATUS);

  assign uart_tx_data  = txMem[txRd[AW-1:0]];
  assign uart_tx_valid = !txEmpty;
  assign uart_rx_ready = !rxFull;

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWr[AW-1:0]] <= wdata[7:0];
    if (rxPush) rxMem[rxWr[AW-1:0]] <= uart_rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txWr       <= '0;
      txRd       <= '0;
      rxWr       <= '0;
      rxRd       <= '0;
      txOverflow <= 1'b0;
    end else begin
      if (txPush) txWr <= txWr + (AW+1)'(1);
      if (txPop)  txRd <= txRd + (AW+1)'(1);
      if (rxPush) rxWr <= rxWr + (AW+1)'(1);
      if (rxPop)  rxRd <= rxRd + (AW+1)'(1);
      // A drop in the same cycle as a STATUS read must not be lost.
      if (txWriteHit && txFull) txOverflow <= 1'b1;
      else if (statusRead)      txOverflow <= 1'b0;
    end
  end

`ifdef MMIO_COUNTERS_EN
  logic [31:0] cycles, instrs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles <= '0;
      instrs <= '0;
    end else begin
      cycles <= (wrAccess && offset == OFF_CYCLES) ? '0 : cycles + 32'd1;
      instrs <= (wrAccess && offset == OFF_INSTRS) ? '0 : instrs + {31'b0, instr_retire};
    end
  end
`endif

  logic [31:0] readValue;

  // NOTE: readValue gets a default before the case so no latch is inferred.
  always_comb begin
    readValue = '0;
    case (offset)
      OFF_STATUS: readValue = {29'b0, txOverflow, !rxEmpty, !txFull};
      OFF_RXDATA: readValue = rxEmpty ? 32'b0 : {24'b0, rxMem[rxRd[AW-1:0]]};
`ifdef MMIO_COUNTERS_EN
      OFF_CYCLES: readValue = cycles;
      OFF_INSTRS: readValue = instrs;
`endif
      default:    readValue = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rdata <= '0;
    else if (rdAccess) rdata <= readValue;
  end

  logic unusedBits;
`ifdef MMIO_COUNTERS_EN
  assign unusedBits = ^{addr[27:8], addr[1:0], wdata[31:8]};
`else
  assign unusedBits = ^{addr[27:8], addr[1:0], wdata[31:8], instr_retire};
`endif

endmodule
